hdlc_tx_framer: RTL and testbench

Parametrised HDLC transmit framer: it buffers a frame of bytes, then serialises it with opening and closing flags, an optional CRC-16/X.25 FCS, zero-bit insertion and abort support. It replaces the controller/buffer/FCS/channel transmit chain of the HDLC block with a single block. Buffer depth, FCS generation and idle-line mode are configurable. It sits between the register interface (byte writes, start, abort) and the serial line.

---
 rtl/hdlc_tx_framer.sv | 204 ++++++++++++++++++++
 tb/tb_hdlc_tx_framer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: byte buffer, flags, CRC-16/X.25 FCS, zero-bit insertion
// and abort pattern, serialised one bit per TxEN strobe.
// state      | meaning
// IDLE       | buffer writable, line idles (1s or back-to-back flags)
// OPEN_FLAG  | finish any idle flag in progress, then send opening 0x7E
// DATA       | send buffered bytes LSB first with zero insertion
// FCS        | send complemented CRC, low byte first, with zero insertion
// CLOSE_FLAG | send closing 0x7E, then clear buffer and pulse FrameSent
// ABORT      | send 0xFE unstuffed, then clear buffer and pulse AbortedTrans
module hdlc_tx_framer #(
   parameter int BUFF_DEPTH = 128,
   parameter int FCS_EN     = 1,
   parameter int IDLE_FLAGS = 0
) (
   input  logic                              Clk,
   input  logic                              Rst,
   input  logic                              WrBuff,
   input  logic [7:0]                        DataIn,
   input  logic                              Start,
   input  logic                              Abort,
   input  logic                              TxEN,
   output logic                              Tx,
   output logic                              Done,
   output logic                              Full,
   output logic [$clog2(BUFF_DEPTH+1)-1:0]   FrameSize,
   output logic                              FrameSent,
   output logic                              AbortedTrans
);
   localparam int AW = $clog2(BUFF_DEPTH);
   localparam int SW = $clog2(BUFF_DEPTH+1);
   localparam logic [7:0]  FLAG      = 8'h7E;
   localparam logic [7:0]  ABORT_PAT = 8'hFE;
   localparam logic [15:0] CRC_INIT  = 16'hFFFF;
   localparam logic [15:0] CRC_POLY  = 16'h8408;

   typedef enum logic [2:0] {
      S_IDLE, S_OPEN_FLAG, S_DATA, S_FCS, S_CLOSE_FLAG, S_ABORT
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [7:0]    r_mem [BUFF_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [SW-1:0] r_size, r_sent;
   logic [2:0]    r_bit_cnt, r_ones;
   logic [3:0]    r_fcs_idx;
   logic [15:0]   r_crc;
   logic          r_pad, r_tail, r_tx, r_frame_sent, r_aborted;

   logic          w_wr_ok, w_start, w_abort, w_stuff, w_bit, w_ones_hit;
   logic          w_last_data, w_last_fcs, w_crc_fb;
   logic [2:0]    w_idle_cnt_nxt;
   logic [15:0]   w_crc_nxt;

   assign Full         = (r_size == SW'(BUFF_DEPTH));
   assign Done         = (r_state == S_IDLE);
   assign FrameSize    = r_size;
   assign Tx           = r_tx;
   assign FrameSent    = r_frame_sent;
   assign AbortedTrans = r_aborted;

   assign w_wr_ok        = WrBuff && Done && !Full;
   assign w_start        = Start && Done && ((r_size != '0) || w_wr_ok);
   assign w_abort        = Abort && (r_state inside {S_OPEN_FLAG, S_DATA, S_FCS});
   assign w_stuff        = (r_state == S_DATA || r_state == S_FCS) && (r_ones == 3'd5);
   assign w_last_data    = (r_bit_cnt == 3'd7) && ((r_sent + SW'(1)) == r_size);
   assign w_last_fcs     = (r_fcs_idx == 4'd15);
   assign w_ones_hit     = w_bit && (r_ones == 3'd4);
   assign w_crc_fb       = r_crc[0] ^ w_bit;
   assign w_crc_nxt      = w_crc_fb ? ((r_crc >> 1) ^ CRC_POLY) : (r_crc >> 1);
   assign w_idle_cnt_nxt = TxEN ? r_bit_cnt + 3'd1 : r_bit_cnt;

   // A pending stuff bit after the final FCS (or data) bit is held off the
   // closing flag by r_tail so the flag never follows five unstuffed 1s.
   always_comb begin
      w_state_nxt = r_state;
      w_bit       = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_bit = (IDLE_FLAGS != 0) ? FLAG[r_bit_cnt] : 1'b1;
            if (w_start) w_state_nxt = S_OPEN_FLAG;
         end
         S_OPEN_FLAG: begin
            w_bit = FLAG[r_bit_cnt];
            if (TxEN && r_bit_cnt == 3'd7 && !r_pad) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_bit = w_stuff ? 1'b0 : r_mem[r_rd_ptr][r_bit_cnt];
            if (TxEN) begin
               if (w_stuff) begin
                  if (r_tail) w_state_nxt = S_CLOSE_FLAG;
               end else if (w_last_data) begin
                  if (FCS_EN != 0)     w_state_nxt = S_FCS;
                  else if (!w_ones_hit) w_state_nxt = S_CLOSE_FLAG;
               end
            end
         end
         S_FCS: begin
            w_bit = w_stuff ? 1'b0 : ~r_crc[r_fcs_idx];
            if (TxEN) begin
               if (w_stuff) begin
                  if (r_tail) w_state_nxt = S_CLOSE_FLAG;
               end else if (w_last_fcs && !w_ones_hit) begin
                  w_state_nxt = S_CLOSE_FLAG;
               end
            end
         end
         S_CLOSE_FLAG: begin
            w_bit = FLAG[r_bit_cnt];
            if (TxEN && r_bit_cnt == 3'd7) w_state_nxt = S_IDLE;
         end
         S_ABORT: begin
            w_bit = ABORT_PAT[r_bit_cnt];
            if (TxEN && r_bit_cnt == 3'd7) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) w_state_nxt = S_ABORT;
   end

   always_ff @(posedge Clk) begin
      if (w_wr_ok) r_mem[r_wr_ptr] <= DataIn;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_size       <= '0;
         r_sent       <= '0;
         r_bit_cnt    <= '0;
         r_ones       <= '0;
         r_fcs_idx    <= '0;
         r_crc        <= CRC_INIT;
         r_pad        <= 1'b0;
         r_tail       <= 1'b0;
         r_tx         <= 1'b1;
         r_frame_sent <= 1'b0;
         r_aborted    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_frame_sent <= 1'b0;
         r_aborted    <= 1'b0;
         if (TxEN) r_tx <= w_bit;
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_size   <= r_size + SW'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (IDLE_FLAGS != 0) r_bit_cnt <= w_idle_cnt_nxt;
               if (w_start) begin
                  r_pad  <= (IDLE_FLAGS != 0) && (w_idle_cnt_nxt != 3'd0);
                  r_ones <= '0;
               end
            end
            S_OPEN_FLAG: if (TxEN) begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) r_pad <= 1'b0;
            end
            S_DATA, S_FCS: if (TxEN) begin
               if (w_stuff) begin
                  r_ones <= '0;
                  r_tail <= 1'b0;
               end else begin
                  r_ones <= w_bit ? r_ones + 3'd1 : 3'd0;
                  if (r_state == S_DATA) begin
                     r_crc     <= w_crc_nxt;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                        r_sent   <= r_sent + SW'(1);
                     end
                     if (w_last_data && FCS_EN == 0 && w_ones_hit) r_tail <= 1'b1;
                  end else begin
                     r_fcs_idx <= r_fcs_idx + 4'd1;
                     if (w_last_fcs && w_ones_hit) r_tail <= 1'b1;
                  end
               end
            end
            S_CLOSE_FLAG, S_ABORT: if (TxEN) begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  r_wr_ptr     <= '0;
                  r_rd_ptr     <= '0;
                  r_size       <= '0;
                  r_sent       <= '0;
                  r_fcs_idx    <= '0;
                  r_ones       <= '0;
                  r_crc        <= CRC_INIT;
                  r_frame_sent <= (r_state == S_CLOSE_FLAG);
                  r_aborted    <= (r_state == S_ABORT);
               end
            end
            default: ;
         endcase
         if (w_abort) begin
            r_bit_cnt <= '0;
            r_pad     <= 1'b0;
            r_tail    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Bench for hdlc_tx_framer: captures the serial line on each strobe and compares
// it against a frame built from bytes, CRC and bit-stuffing rules.
module tb_hdlc_tx_framer;
   typedef bit         bit_q_t[$];
   typedef logic [7:0] byte_q_t[$];

   logic       Clk = 1'b0;
   logic       Rst, WrBuff, Start, Abort, TxEN;
   logic [7:0] DataIn;
   logic       Tx0, Done0, Full0, FrameSent0, AbortedTrans0;
   logic [7:0] FrameSize0;
   logic       Tx1, Done1, Full1, FrameSent1, AbortedTrans1;
   logic [3:0] FrameSize1;

   int      checks = 0;
   int      errors = 0;
   int      tx_div = 1;
   int      div_cnt = 0;
   int      nstrobe = 0;
   logic    strobe_seen = 1'b0;
   bit_q_t  cap;
   bit      got_sent, got_abort, timed_out;

   hdlc_tx_framer #(.BUFF_DEPTH(128), .FCS_EN(1), .IDLE_FLAGS(0)) u_dut0 (
      .Clk(Clk), .Rst(Rst), .WrBuff(WrBuff), .DataIn(DataIn), .Start(Start),
      .Abort(Abort), .TxEN(TxEN), .Tx(Tx0), .Done(Done0), .Full(Full0),
      .FrameSize(FrameSize0), .FrameSent(FrameSent0), .AbortedTrans(AbortedTrans0));

   hdlc_tx_framer #(.BUFF_DEPTH(8), .FCS_EN(1), .IDLE_FLAGS(1)) u_dut1 (
      .Clk(Clk), .Rst(Rst), .WrBuff(WrBuff), .DataIn(DataIn), .Start(Start),
      .Abort(Abort), .TxEN(TxEN), .Tx(Tx1), .Done(Done1), .Full(Full1),
      .FrameSize(FrameSize1), .FrameSent(FrameSent1), .AbortedTrans(AbortedTrans1));

   always #5 Clk = ~Clk;

   initial begin
      TxEN = 1'b1;
      forever begin
         @(negedge Clk);
         div_cnt++;
         TxEN = ((div_cnt % tx_div) == 0);
      end
   end

   always @(posedge Clk) begin
      strobe_seen <= TxEN;
      if (Rst) nstrobe <= 0;
      else if (TxEN) nstrobe <= nstrobe + 1;
   end

   // ---------------- reference model ----------------
   function automatic logic [15:0] fcs_of(input byte_q_t d);
      logic [15:0] crc = 16'hFFFF;
      foreach (d[k]) begin
         crc = crc ^ {8'h00, d[k]};
         for (int i = 0; i < 8; i++) crc = crc[0] ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
      end
      return ~crc;
   endfunction

   function automatic void build_frame(input byte_q_t d, input bit add_fcs,
                                       output bit_q_t s, output int last_body_idx);
      byte_q_t     body;
      logic [15:0] f;
      logic [7:0]  flag = 8'h7E;
      int          ones = 0;
      bit          b;
      body = d;
      if (add_fcs) begin
         f = fcs_of(d);
         body.push_back(f[7:0]);
         body.push_back(f[15:8]);
      end
      s = {};
      last_body_idx = 0;
      for (int i = 0; i < 8; i++) s.push_back(flag[i]);
      foreach (body[k]) begin
         for (int i = 0; i < 8; i++) begin
            b = body[k][i];
            s.push_back(b);
            last_body_idx = s.size() - 1;
            ones = b ? ones + 1 : 0;
            if (ones == 5) begin
               s.push_back(1'b0);
               ones = 0;
            end
         end
      end
      for (int i = 0; i < 8; i++) s.push_back(flag[i]);
   endfunction

   function automatic int first_diff(input bit_q_t a, input bit_q_t b);
      int n = (a.size() < b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
      if (a.size() != b.size()) return n;
      return -1;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge Clk); Rst = 1'b1; WrBuff = 1'b0; Start = 1'b0; Abort = 1'b0;
      @(negedge Clk); Rst = 1'b0;
   endtask

   task automatic wr_bytes(input byte_q_t d);
      foreach (d[i]) begin
         @(negedge Clk); WrBuff = 1'b1; DataIn = d[i];
      end
      @(negedge Clk); WrBuff = 1'b0;
   endtask

   task automatic do_start();
      @(negedge Clk); Start = 1'b1;
      @(negedge Clk); Start = 1'b0;
   endtask

   task automatic collect(input int which, input int budget);
      cap = {}; got_sent = 0; got_abort = 0; timed_out = 0;
      for (int c = 0; c < budget; c++) begin
         @(posedge Clk); @(negedge Clk);
         if (which == 0) begin
            if (strobe_seen) cap.push_back(Tx0);
            if (FrameSent0) got_sent = 1;
            if (AbortedTrans0) got_abort = 1;
         end else begin
            if (strobe_seen) cap.push_back(Tx1);
            if (FrameSent1) got_sent = 1;
            if (AbortedTrans1) got_abort = 1;
         end
         if (got_sent || got_abort) return;
      end
      timed_out = 1;
   endtask

   function automatic byte_q_t rand_bytes(input int n);
      byte_q_t d;
      for (int i = 0; i < n; i++) d.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      return d;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++; if (Tx0 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", Tx0); end
      checks++; if (Done0 !== 1'b1) begin errors++; $display("FAIL reset_done: got %b want 1", Done0); end
      checks++; if (Full0 !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", Full0); end
      checks++; if (FrameSize0 !== 8'd0) begin errors++; $display("FAIL reset_size: got %0d want 0", FrameSize0); end
      checks++; if (FrameSent0 !== 1'b0 || AbortedTrans0 !== 1'b0) begin
         errors++; $display("FAIL reset_pulses: got sent=%b abort=%b want 0/0", FrameSent0, AbortedTrans0); end
      checks++; if (Tx1 !== 1'b1 || Done1 !== 1'b1) begin
         errors++; $display("FAIL reset_dut1: got tx=%b done=%b want 1/1", Tx1, Done1); end
      do_start();
      repeat (20) @(negedge Clk);
      checks++; if (Done0 !== 1'b1 || Tx0 !== 1'b1) begin
         errors++; $display("FAIL empty_start: got done=%b tx=%b want 1/1", Done0, Tx0); end
   endtask

   task automatic test_known_vector();
      byte_q_t d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      byte_q_t e;
      bit_q_t  s;
      int      li, df;
      e = d; e.push_back(8'h6E); e.push_back(8'h90);
      build_frame(e, 0, s, li);
      wr_bytes(d);
      checks++; if (FrameSize0 !== 8'd9) begin errors++; $display("FAIL kv_size: got %0d want 9", FrameSize0); end
      do_start();
      checks++; if (Done0 !== 1'b0) begin errors++; $display("FAIL kv_done_fall: got %b want 0", Done0); end
      collect(0, 500);
      checks++; if (timed_out || !got_sent) begin errors++; $display("FAIL kv_sent: got timeout=%b sent=%b want 0/1", timed_out, got_sent); end
      checks++; if (cap.size() != 104) begin errors++; $display("FAIL kv_len: got %0d bits want 104", cap.size()); end
      df = first_diff(cap, s);
      checks++; if (df != -1) begin errors++; $display("FAIL kv_stream: first difference at bit %0d want none", df); end
      checks++; if (Done0 !== 1'b1) begin errors++; $display("FAIL kv_done_rise: got %b want 1", Done0); end
      @(negedge Clk);
      checks++; if (FrameSent0 !== 1'b0 || FrameSize0 !== 8'd0) begin
         errors++; $display("FAIL kv_after: got sent=%b size=%0d want 0/0", FrameSent0, FrameSize0); end
   endtask

   task automatic test_stuffing();
      byte_q_t d = '{8'hFF, 8'hFF};
      bit_q_t  s;
      int      pat[19] = '{1,1,1,1,1,0,1,1,1,1,1,0,1,1,1,1,1,0,1};
      int      li, df, bad;
      build_frame(d, 1, s, li);
      wr_bytes(d);
      do_start();
      collect(0, 500);
      checks++; if (timed_out || !got_sent) begin errors++; $display("FAIL stuff_sent: got timeout=%b sent=%b want 0/1", timed_out, got_sent); end
      bad = 0;
      for (int i = 0; i < 19; i++) if (cap.size() <= 8 + i || cap[8+i] != pat[i][0]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL stuff_field: got %0d wrong bits want 0", bad); end
      df = first_diff(cap, s);
      checks++; if (df != -1) begin errors++; $display("FAIL stuff_stream: first difference at bit %0d want none (len %0d vs %0d)", df, cap.size(), s.size()); end
   endtask

   task automatic test_random_frames();
      byte_q_t d;
      bit_q_t  s;
      int      li, df;
      for (int it = 0; it < 4; it++) begin
         d = rand_bytes($urandom_range(1, 12));
         build_frame(d, 1, s, li);
         wr_bytes(d);
         do_start();
         collect(0, 500);
         df = first_diff(cap, s);
         checks++; if (timed_out || !got_sent || df != -1) begin
            errors++; $display("FAIL rand_frame%0d: got timeout=%b sent=%b diff=%0d want 0/1/-1", it, timed_out, got_sent, df); end
      end
   endtask

   task automatic test_wr_start_same();
      byte_q_t d;
      bit_q_t  s;
      int      li, df;
      d = rand_bytes(3);
      build_frame(d, 1, s, li);
      wr_bytes(d[0:1]);
      @(negedge Clk); WrBuff = 1'b1; DataIn = d[2]; Start = 1'b1;
      @(negedge Clk); WrBuff = 1'b0; Start = 1'b0;
      collect(0, 500);
      df = first_diff(cap, s);
      checks++; if (timed_out || df != -1) begin
         errors++; $display("FAIL wr_start_same: got timeout=%b diff=%0d want 0/-1", timed_out, df); end
   endtask

   task automatic test_full();
      byte_q_t d;
      byte_q_t one = '{8'hA5};
      bit_q_t  s;
      int      li, df;
      d = rand_bytes(128);
      build_frame(d, 1, s, li);
      wr_bytes(d);
      checks++; if (Full0 !== 1'b1 || FrameSize0 !== 8'd128) begin
         errors++; $display("FAIL full_set: got full=%b size=%0d want 1/128", Full0, FrameSize0); end
      wr_bytes(one);
      checks++; if (FrameSize0 !== 8'd128) begin errors++; $display("FAIL full_ignore: got %0d want 128", FrameSize0); end
      do_start();
      collect(0, 4000);
      df = first_diff(cap, s);
      checks++; if (timed_out || df != -1) begin
         errors++; $display("FAIL full_stream: got timeout=%b diff=%0d want 0/-1", timed_out, df); end
      checks++; if (FrameSize0 !== 8'd0 || Full0 !== 1'b0) begin
         errors++; $display("FAIL full_clear: got size=%0d full=%b want 0/0", FrameSize0, Full0); end
   endtask

   task automatic abort_run(input string name, input byte_q_t d, input int a);
      bit_q_t s, e;
      int     li, df;
      build_frame(d, 1, s, li);
      if (a == 0) a = li + 1;
      e = {};
      for (int i = 0; i < a; i++) e.push_back(s[i]);
      e.push_back(1'b0);
      for (int i = 0; i < 7; i++) e.push_back(1'b1);
      wr_bytes(d);
      do_start();
      fork
         collect(0, 300);
         begin
            repeat (a - 1) @(negedge Clk);
            Abort = 1'b1;
            @(negedge Clk); Abort = 1'b0;
         end
      join
      checks++; if (timed_out || !got_abort || got_sent) begin
         errors++; $display("FAIL %s_pulse: got timeout=%b abort=%b sent=%b want 0/1/0", name, timed_out, got_abort, got_sent); end
      df = first_diff(cap, e);
      checks++; if (df != -1) begin errors++; $display("FAIL %s_stream: first difference at bit %0d want none", name, df); end
      checks++; if (FrameSize0 !== 8'd0 || Done0 !== 1'b1) begin
         errors++; $display("FAIL %s_clear: got size=%0d done=%b want 0/1", name, FrameSize0, Done0); end
      repeat (20) @(negedge Clk);
      checks++; if (Tx0 !== 1'b1) begin errors++; $display("FAIL %s_idle: got tx=%b want 1", name, Tx0); end
   endtask

   task automatic test_abort();
      abort_run("abort_data", rand_bytes(5), 8 + 16 + $urandom_range(1, 8));
      abort_run("abort_last_fcs", rand_bytes(3), 0);
   endtask

   task automatic test_reset_mid_data();
      int pulses = 0, bad_tx = 0;
      wr_bytes(rand_bytes(6));
      do_start();
      repeat (20) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      checks++; if (Tx0 !== 1'b1 || Done0 !== 1'b1 || FrameSize0 !== 8'd0) begin
         errors++; $display("FAIL rst_mid: got tx=%b done=%b size=%0d want 1/1/0", Tx0, Done0, FrameSize0); end
      Rst = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge Clk);
         if (FrameSent0 || AbortedTrans0) pulses++;
         if (Tx0 !== 1'b1) bad_tx++;
      end
      checks++; if (pulses != 0 || bad_tx != 0) begin
         errors++; $display("FAIL rst_quiet: got pulses=%0d non-idle bits=%0d want 0/0", pulses, bad_tx); end
   endtask

   task automatic test_idle_flags();
      byte_q_t    d;
      bit_q_t     s, tail;
      logic [7:0] flag = 8'h7E;
      int         li, df, p, bad;
      bit         aligned = 0;
      tx_div = 3;
      d = rand_bytes(4);
      build_frame(d, 1, s, li);
      do_reset();
      fork
         collect(1, 3000);
         begin
            wr_bytes(d);
            for (int k = 0; k < 200 && !aligned; k++) begin
               if ((nstrobe % 8) == 3) aligned = 1;
               else @(negedge Clk);
            end
            do_start();
         end
      join
      checks++; if (!aligned) begin errors++; $display("FAIL idle_midflag: got no mid-flag start point want one"); end
      checks++; if (timed_out || !got_sent) begin
         errors++; $display("FAIL idle_sent: got timeout=%b sent=%b want 0/1", timed_out, got_sent); end
      p = cap.size() - s.size();
      checks++; if (p < 8 || (p % 8) != 0) begin errors++; $display("FAIL idle_boundary: got prefix %0d bits want positive multiple of 8", p); end
      bad = 0;
      for (int i = 0; i < p && i < cap.size(); i++) if (cap[i] != flag[i % 8]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL idle_flags: got %0d bad idle bits want 0", bad); end
      tail = {};
      for (int i = (p < 0 ? 0 : p); i < cap.size(); i++) tail.push_back(cap[i]);
      df = first_diff(tail, s);
      checks++; if (df != -1) begin errors++; $display("FAIL idle_frame: first difference at bit %0d want none", df); end
      checks++; if (Done1 !== 1'b1) begin errors++; $display("FAIL idle_done: got %b want 1", Done1); end
      tx_div = 1;
   endtask

   initial begin
      Rst = 1'b1; WrBuff = 1'b0; Start = 1'b0; Abort = 1'b0; DataIn = 8'h00;
      test_reset();
      test_known_vector();
      test_stuffing();
      test_random_frames();
      test_wr_start_same();
      test_full();
      test_abort();
      test_reset_mid_data();
      test_idle_flags();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
